// File: rtl/counter_sequencer.sv
// Run/pause/clear sequencer for the hex-display counter chain: prescaled Enable
// pulses, synchronous clear requests, and a one-shot or wrapping terminal count.
module counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Clear,
    input  logic             Wrap,
    input  logic [WIDTH-1:0] Limit,
    input  logic [WIDTH-1:0] Count,
    output logic             Enable,
    output logic             ClearCnt,
    output logic             Running,
    output logic             Done,
    output logic [1:0]       State
);
    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          start_prev_q, stop_prev_q, clear_prev_q;
    logic          enable_q, enable_d;
    logic          clearcnt_q, clearcnt_d;
    logic          clear_edge, stop_raw, stop_edge, start_edge;
    logic          tick, at_limit;

    // Only the highest-priority edge of a cycle is allowed to act.
    assign clear_edge = Clear & ~clear_prev_q;
    assign stop_raw   = Stop & ~stop_prev_q;
    assign stop_edge  = stop_raw & ~clear_edge;
    assign start_edge = Start & ~start_prev_q & ~clear_edge & ~stop_raw;

    assign tick     = (state_q == S_RUN) && (div_q == DIV_LAST) && !stop_edge && !clear_edge;
    assign at_limit = (Count >= Limit);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        enable_d   = 1'b0;
        clearcnt_d = 1'b0;
        if (clear_edge) begin
            state_d    = S_IDLE;
            div_d      = '0;
            clearcnt_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end
                end
                S_RUN: begin
                    if (stop_edge) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        div_d = '0;
                        if (!at_limit) begin
                            enable_d = 1'b1;
                        end else if (Wrap) begin
                            clearcnt_d = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        div_d = div_q + DW'(1);
                    end
                end
                S_PAUSE: begin
                    // Resume keeps the prescaler phase.
                    if (start_edge) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            clear_prev_q <= 1'b0;
            enable_q     <= 1'b0;
            clearcnt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            start_prev_q <= Start;
            stop_prev_q  <= Stop;
            clear_prev_q <= Clear;
            enable_q     <= enable_d & ~clearcnt_d;
            clearcnt_q   <= clearcnt_d;
        end
    end

    assign Enable   = enable_q;
    assign ClearCnt = clearcnt_q;
    assign Running  = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
    assign State    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a 4-bit counter model closes the Count loop and
// per-cycle expected output words are queued as stimulus is applied.
module tb_counter_sequencer;
    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic             Clock, Resetn, Start, Stop, Clear, Wrap;
    logic [WIDTH-1:0] Limit, Count;
    logic             Enable, ClearCnt, Running, Done;
    logic [1:0]       State;

    logic             load_en;
    logic [WIDTH-1:0] load_val, cnt_q;
    logic [5:0]       exp_q[$];
    logic [5:0]       obs, exp_w, e;
    int               checks, errors;

    counter_sequencer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop), .Clear(Clear),
        .Wrap(Wrap), .Limit(Limit), .Count(Count), .Enable(Enable), .ClearCnt(ClearCnt),
        .Running(Running), .Done(Done), .State(State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Counter being sequenced: clear beats increment, load is a bench-only preset.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn)       cnt_q <= '0;
        else if (load_en)  cnt_q <= load_val;
        else if (ClearCnt) cnt_q <= '0;
        else if (Enable)   cnt_q <= cnt_q + 1'b1;
    end
    assign Count = cnt_q;

    function automatic logic [5:0] ew(input logic [1:0] st, input logic en, input logic cc);
        return {st, st == ST_RUN, st == ST_DONE, en, cc};
    endfunction

    task automatic test_reset();
        for (int j = 0; j < 4; j++) begin
            Start = ~Start;
            exp_q.push_back(ew(ST_IDLE, 1'b0, 1'b0));
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", j, obs, exp_w);
            end
        end
        Start = 1'b0;
        #3 Resetn = 1'b1;
        for (int m = 0; m <= 12; m++) begin
            if (m == 0) Start = 1'b1;
            exp_q.push_back(ew(ST_RUN, (m > 0) && (m % 4 == 0), 1'b0));
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL start_cadence cycle %0d: got %b expected %b", m, obs, exp_w);
            end
        end
    endtask

    task automatic test_one_shot();
        for (int m = 13; m <= 21; m++) begin
            exp_q.push_back((m < 16) ? ew(ST_RUN, 1'b0, 1'b0) : ew(ST_DONE, 1'b0, 1'b0));
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL one_shot cycle %0d: got %b expected %b", m, obs, exp_w);
            end
        end
        checks++;
        if (cnt_q !== 4'd3) begin
            errors++;
            $display("FAIL one_shot_count: got %0d expected 3", cnt_q);
        end
    endtask

    task automatic test_wrap();
        for (int j = 0; j <= 23; j++) begin
            case (j)
                0: begin Clear = 1'b1; Start = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b1); end
                1: begin Clear = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b0); end
                2: begin Wrap = 1'b1; Start = 1'b1; e = ew(ST_RUN, 1'b0, 1'b0); end
                default: e = ew(ST_RUN, ((j - 2) % 4 == 0) && (j - 2 != 16), (j - 2 == 16));
            endcase
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL wrap cycle %0d: got %b expected %b", j, obs, exp_w);
            end
        end
        checks++;
        if (cnt_q !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected 1", cnt_q);
        end
    endtask

    task automatic test_pause_resume();
        for (int i = 0; i <= 28; i++) begin
            case (i)
                1:  Stop  = 1'b1;
                2:  Start = 1'b0;
                3:  Stop  = 1'b0;
                22: Start = 1'b1;
                default: ;
            endcase
            if (i == 0 || i >= 22) e = ew(ST_RUN, (i == 24) || (i == 28), 1'b0);
            else                   e = ew(ST_PAUSE, 1'b0, 1'b0);
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL pause_resume cycle %0d: got %b expected %b", i, obs, exp_w);
            end
        end
        checks++;
        if (cnt_q !== 4'd2) begin
            errors++;
            $display("FAIL pause_count: got %0d expected 2", cnt_q);
        end
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j <= 9; j++) begin
            case (j)
                3: begin Stop = 1'b1; e = ew(ST_PAUSE, 1'b0, 1'b0); end
                4: begin Stop = 1'b0; Start = 1'b0; e = ew(ST_PAUSE, 1'b0, 1'b0); end
                5: begin Start = 1'b1; e = ew(ST_RUN, 1'b0, 1'b0); end
                6: e = ew(ST_RUN, 1'b0, 1'b1);
                7: begin Start = 1'b0; e = ew(ST_RUN, 1'b0, 1'b0); end
                8: begin Start = 1'b1; Clear = 1'b1; e = ew(ST_IDLE, 1'b0, 1'b1); end
                9: begin Start = 1'b0; Clear = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b0); end
                default: e = ew(ST_RUN, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got %b expected %b", j, obs, exp_w);
            end
        end
        checks++;
        if (cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL simultaneous_count: got %0d expected 0", cnt_q);
        end
    endtask

    task automatic test_live_limit();
        for (int j = 0; j <= 10; j++) begin
            case (j)
                0: begin load_en = 1'b1; load_val = 4'd5; Limit = 4'd15; Wrap = 1'b0;
                         e = ew(ST_IDLE, 1'b0, 1'b0); end
                1: begin load_en = 1'b0; Start = 1'b1; e = ew(ST_RUN, 1'b0, 1'b0); end
                3: begin Limit = 4'd2; e = ew(ST_RUN, 1'b0, 1'b0); end
                2, 4: e = ew(ST_RUN, 1'b0, 1'b0);
                6: begin Start = 1'b0; e = ew(ST_DONE, 1'b0, 1'b0); end
                7: begin Start = 1'b1; e = ew(ST_DONE, 1'b0, 1'b0); end
                9: begin Clear = 1'b1; e = ew(ST_IDLE, 1'b0, 1'b1); end
                10: begin Clear = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b0); end
                default: e = ew(ST_DONE, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL live_limit cycle %0d: got %b expected %b", j, obs, exp_w);
            end
            if (j == 8) begin
                checks++;
                if (cnt_q !== 4'd5) begin
                    errors++;
                    $display("FAIL live_limit_count: got %0d expected 5", cnt_q);
                end
            end
        end
    endtask

    task automatic test_clear_in_flight();
        for (int j = 0; j <= 7; j++) begin
            case (j)
                0: begin Limit = 4'd15; Start = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b0); end
                1: begin Start = 1'b1; e = ew(ST_RUN, 1'b0, 1'b0); end
                5: e = ew(ST_RUN, 1'b1, 1'b0);
                6: begin Clear = 1'b1; e = ew(ST_IDLE, 1'b0, 1'b1); end
                7: begin Clear = 1'b0; e = ew(ST_IDLE, 1'b0, 1'b0); end
                default: e = ew(ST_RUN, 1'b0, 1'b0);
            endcase
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL clear_in_flight cycle %0d: got %b expected %b", j, obs, exp_w);
            end
            if (j == 6 || j == 7) begin
                checks++;
                if (cnt_q !== ((j == 6) ? 4'd1 : 4'd0)) begin
                    errors++;
                    $display("FAIL clear_in_flight_count cycle %0d: got %0d expected %0d",
                             j, cnt_q, (j == 6) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int j = 0; j <= 5; j++) begin
            if (j == 0) Start = 1'b0;
            if (j == 1) Start = 1'b1;
            e = (j == 0) ? ew(ST_IDLE, 1'b0, 1'b0) : ew(ST_RUN, j == 5, 1'b0);
            exp_q.push_back(e);
            @(posedge Clock); #1;
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL reset_mid_run cycle %0d: got %b expected %b", j, obs, exp_w);
            end
        end
        #2 Resetn = 1'b0;
        Start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_q.push_back(ew(ST_IDLE, 1'b0, 1'b0));
            if (j == 0) #1;
            else begin
                if (j == 2) #3 Resetn = 1'b1;
                @(posedge Clock); #1;
            end
            obs = {State, Running, Done, Enable, ClearCnt};
            exp_w = exp_q.pop_front();
            checks++;
            if (obs !== exp_w) begin
                errors++;
                $display("FAIL reset_async step %0d: got %b expected %b", j, obs, exp_w);
            end
        end
        checks++;
        if (cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_async_count: got %0d expected 0", cnt_q);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        Resetn   = 1'b0;
        Start    = 1'b0;
        Stop     = 1'b0;
        Clear    = 1'b0;
        Wrap     = 1'b0;
        Limit    = 4'd3;
        load_en  = 1'b0;
        load_val = '0;
        test_reset();
        test_one_shot();
        test_wrap();
        test_pause_resume();
        test_simultaneous();
        test_live_limit();
        test_clear_in_flight();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
